legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
Parametrised multicycle control and sequencing core for the LEGv8 datapath. It replaces the single-pass PC/IM/ID front end with an FSM-driven fetch/decode/execute/memory/writeback sequence. It adds ready/request handshakes to instruction and data memory, PC-relative branching (CBZ, B), an illegal-opcode halt and a retired-instruction counter. It drives the existing RF/ALU/DM datapath control inputs and consumes that datapath's Zero flag.

Parameters:
ADDR_W, 64, PC and memory address width.
PC_RESET, 0, PC value loaded on reset.
CNT_W, 32, width of retired-instruction counter.

Ports:
Clock  in  1  rising-edge system clock
Reset_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  fetch complete, imem_rdata valid
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data memory request (LDUR/STUR)
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ready  in  1  data access complete
alu_zero  in  1  datapath Zero flag
inst_out  out  32  instruction register, drives datapath field slices
pc  out  ADDR_W  current PC
Reg2Loc, ALUSrc, MemtoReg, RegWrite  out  1 each  datapath controls
ALUOp  out  2  ALU operation class
retired  out  CNT_W  instructions retired since reset
halted  out  1  illegal opcode trapped

Behaviour:
- Reset (Reset_n low, async): state=RST, pc=PC_RESET, inst_out=0, retired=0, halted=0, all request/control outputs 0. RST→FETCH on the first Clock edge after release.
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is held in the package.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ready is sampled high. Zero-wait is allowed: ready in the first FETCH cycle. On ready: inst_out←imem_rdata, pc_inst←pc, →DECODE.
- DECODE: pc←pc_inst+4. Decode on inst_out[31:21]:
  - LDUR 0x7C2, STUR 0x7C0, ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 → EXEC.
  - CBZ when [31:24]=0xB4 → EXEC.
  - B when [31:26]=0x05: pc←pc_inst+(sext(imm26)<<2), retired+1, →FETCH.
  - Anything else → HALT.
- EXEC:
  - R-type (ADD/SUB/AND/ORR): ALUOp=10, →WB.
  - LDUR/STUR: ALUSrc=1, ALUOp=00, →MEM.
  - CBZ: Reg2Loc=1, ALUOp=01. If alu_zero then pc←pc_inst+(sext(imm19 [23:5])<<2). retired+1, →FETCH.
- MEM: dmem_req=1, dmem_we=(STUR), held until dmem_ready.
  - STUR (Reg2Loc=1 held): retired+1, →FETCH.
  - LDUR: →WB.
- WB: RegWrite=1 for exactly one cycle. MemtoReg=1 for LDUR. retired+1, →FETCH.
- Control outputs are combinational from state plus the latched opcode. They are 0 in any state where not listed.
- Latency with zero-wait memory: B 2, CBZ 3, R-type 4, STUR 4, LDUR 5 cycles. Each memory wait cycle adds 1.
- Branch arithmetic: sign-extend to ADDR_W, modulo 2^ADDR_W wrap. No alignment check.
- retired wraps from all-ones to 0.
- HALT: halted=1, no requests issued. Stays in HALT until Reset_n.
- Reset mid-handshake: requests drop immediately (async). Memory must tolerate an abandoned request.

Optional Feature:
Macro CPU_PERF_CNT_EN.
- Defined: adds outputs cycles (CNT_W) and stall_cycles (CNT_W), both reset to 0.
  - cycles increments every Clock edge outside RST/HALT.
  - stall_cycles increments on each FETCH or MEM cycle whose ready is low.
  - Both wrap.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
Package legv8_pkg holds:
- state enum.
- Opcode constants (OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ8, OP_B6).
- ALUOp constants.
- Function branch_offset(inst, is_cbz) returning the ADDR_W sign-extended byte offset.

One sub-module, legv8_decode, is natural: combinational opcode → instruction class plus the control-signal table. The FSM, PC and counters stay in the top.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=0x8B020020 (ADD) at pc 0 → imem_addr 0, RegWrite pulse in cycle 4, pc=4, retired=1.
- LDUR 0xF8400020 with dmem_ready delayed 2 cycles → dmem_req high 3 cycles with dmem_we=0, MemtoReg=RegWrite=1 in WB, 7 cycles total.
- CBZ 0xB4000060 at pc 0x10: alu_zero=1 → pc=0x1C; alu_zero=0 → pc=0x14; both retire in 3 cycles.
- B 0x17FFFFFF at pc 0x20 → pc=0x1C after DECODE; no dmem_req, no RegWrite.
- Illegal 0x00000000 → halted=1 from cycle 3; imem_req stays 0; pulse Reset_n low → pc=0, halted=0.
- Reset_n asserted mid-FETCH with imem_ready=0 → imem_req=0 immediately; retired=0; refetch from PC_RESET after release.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types, opcode constants and branch-offset helper for the LEGv8
// multicycle controller.
package legv8_pkg;

    // Widest supported address; offsets are built at this width and truncated.
    localparam int unsigned MAX_ADDR_W = 64;

    typedef enum logic [2:0] {
        StRst    = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsIllegal = 3'd0,
        ClsLdur    = 3'd1,
        ClsStur    = 3'd2,
        ClsRtype   = 3'd3,
        ClsCbz     = 3'd4,
        ClsB       = 3'd5
    } inst_cls_e;

    // Opcodes on inst[31:21], CBZ on inst[31:24], B on inst[31:26]
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [7:0]  OP_CBZ8 = 8'hB4;
    localparam logic [5:0]  OP_B6   = 6'h05;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Sign-extended byte offset: imm19 for CBZ, imm26 for B, both scaled by 4.
    function automatic logic [MAX_ADDR_W-1:0] branch_offset(input logic [31:0] inst,
                                                            input logic        is_cbz);
        logic [MAX_ADDR_W-1:0] off;
        off = '0;
        if (is_cbz) begin
            off = {{43{inst[23]}}, inst[23:5], 2'b00};
        end else begin
            off = {{36{inst[25]}}, inst[25:0], 2'b00};
        end
        return off;
    endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Instruction and data memory request/ready bus of the multicycle controller.
interface legv8_multicycle_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/legv8_decode.sv
// Opcode classification and the per-state datapath control table.
module legv8_decode
    import legv8_pkg::*;
(
    input  logic [10:0] i_opcode,
    input  state_e      i_state,
    output inst_cls_e   o_cls,
    output logic        o_reg2loc,
    output logic        o_alusrc,
    output logic        o_memtoreg,
    output logic        o_regwrite,
    output logic [1:0]  o_aluop
);

    inst_cls_e w_cls;

    // Classify the latched opcode
    always_comb begin
        w_cls = ClsIllegal;
        if (i_opcode == OP_LDUR) begin
            w_cls = ClsLdur;
        end else if (i_opcode == OP_STUR) begin
            w_cls = ClsStur;
        end else if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                     i_opcode == OP_AND || i_opcode == OP_ORR) begin
            w_cls = ClsRtype;
        end else if (i_opcode[10:3] == OP_CBZ8) begin
            w_cls = ClsCbz;
        end else if (i_opcode[10:5] == OP_B6) begin
            w_cls = ClsB;
        end
    end

    assign o_cls = w_cls;

    // Control outputs from state and class; zero wherever not asserted
    always_comb begin
        o_reg2loc  = 1'b0;
        o_alusrc   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_aluop    = ALUOP_MEM;
        unique case (i_state)
            StExec: begin
                unique case (w_cls)
                    ClsRtype: o_aluop = ALUOP_RTYPE;
                    ClsLdur:  o_alusrc = 1'b1;
                    ClsStur: begin
                        o_alusrc  = 1'b1;
                        o_reg2loc = 1'b1;
                    end
                    ClsCbz: begin
                        o_reg2loc = 1'b1;
                        o_aluop   = ALUOP_CBZ;
                    end
                    default: ;
                endcase
            end
            // Store data register stays selected while the store is in flight
            StMem:   o_reg2loc = (w_cls == ClsStur);
            StWb: begin
                o_regwrite = 1'b1;
                o_memtoreg = (w_cls == ClsLdur);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle fetch/decode/execute/memory/writeback sequencer with
// memory handshakes, PC-relative branches, illegal-opcode halt and a
// retired-instruction counter. Optional performance counters are enabled
// by defining CPU_PERF_CNT_EN.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    legv8_multicycle_ctrl_if.master mem_bus,
    input  logic                 alu_zero,
    output logic [31:0]          inst_out,
    output logic [ADDR_W-1:0]    pc,
    output logic                 Reg2Loc,
    output logic                 ALUSrc,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic [1:0]           ALUOp,
    output logic [CNT_W-1:0]     retired,
    output logic                 halted
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycles,
    output logic [CNT_W-1:0]     stall_cycles
`endif
);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_W-1:0]     r_pc;
    logic [ADDR_W-1:0]     w_pc_next;
    logic [ADDR_W-1:0]     r_pc_inst;
    logic [ADDR_W-1:0]     w_pc_inst_next;
    logic [31:0]           r_inst;
    logic [31:0]           w_inst_next;
    logic [CNT_W-1:0]      r_retired;
    logic                  w_retire;
    inst_cls_e             w_cls;
    logic [MAX_ADDR_W-1:0] w_boff_full;
    logic [ADDR_W-1:0]     w_boff;

    legv8_decode u_decode (
        .i_opcode   (r_inst[31:21]),
        .i_state    (r_state),
        .o_cls      (w_cls),
        .o_reg2loc  (Reg2Loc),
        .o_alusrc   (ALUSrc),
        .o_memtoreg (MemtoReg),
        .o_regwrite (RegWrite),
        .o_aluop    (ALUOp)
    );

    assign w_boff_full = branch_offset(r_inst, w_cls == ClsCbz);
    assign w_boff      = w_boff_full[ADDR_W-1:0];

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StRst;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, PC/IR updates, retire strobe and memory requests
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_pc_inst_next   = r_pc_inst;
        w_inst_next      = r_inst;
        w_retire         = 1'b0;
        mem_bus.imem_req = 1'b0;
        mem_bus.dmem_req = 1'b0;
        mem_bus.dmem_we  = 1'b0;
        unique case (r_state)
            StRst: w_state_next = StFetch;
            StFetch: begin
                mem_bus.imem_req = 1'b1;
                if (mem_bus.imem_ready) begin
                    w_inst_next    = mem_bus.imem_rdata;
                    w_pc_inst_next = r_pc;
                    w_state_next   = StDecode;
                end
            end
            StDecode: begin
                w_pc_next = r_pc_inst + ADDR_W'(4);
                unique case (w_cls)
                    ClsLdur, ClsStur, ClsRtype, ClsCbz: w_state_next = StExec;
                    ClsB: begin
                        w_pc_next    = r_pc_inst + w_boff;
                        w_retire     = 1'b1;
                        w_state_next = StFetch;
                    end
                    default: w_state_next = StHalt;
                endcase
            end
            StExec: begin
                unique case (w_cls)
                    ClsRtype:         w_state_next = StWb;
                    ClsLdur, ClsStur: w_state_next = StMem;
                    ClsCbz: begin
                        if (alu_zero) begin
                            w_pc_next = r_pc_inst + w_boff;
                        end
                        w_retire     = 1'b1;
                        w_state_next = StFetch;
                    end
                    default: w_state_next = StHalt;
                endcase
            end
            StMem: begin
                mem_bus.dmem_req = 1'b1;
                mem_bus.dmem_we  = (w_cls == ClsStur);
                if (mem_bus.dmem_ready) begin
                    if (w_cls == ClsStur) begin
                        w_retire     = 1'b1;
                        w_state_next = StFetch;
                    end else begin
                        w_state_next = StWb;
                    end
                end
            end
            StWb: begin
                w_retire     = 1'b1;
                w_state_next = StFetch;
            end
            StHalt: w_state_next = StHalt;
            default: w_state_next = StRst;
        endcase
    end

    // Architectural registers: PC, fetched-instruction PC, IR, retire count
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc      <= PC_RESET;
            r_pc_inst <= PC_RESET;
            r_inst    <= '0;
            r_retired <= '0;
        end else begin
            r_pc      <= w_pc_next;
            r_pc_inst <= w_pc_inst_next;
            r_inst    <= w_inst_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign mem_bus.imem_addr = r_pc;
    assign inst_out          = r_inst;
    assign pc                = r_pc;
    assign retired           = r_retired;
    assign halted            = (r_state == StHalt);

`ifdef CPU_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_stall_cycles;

    // Active-cycle and memory-stall counters
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cycles       <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_state != StRst && r_state != StHalt) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            if ((r_state == StFetch && !mem_bus.imem_ready) ||
                (r_state == StMem && !mem_bus.dmem_ready)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign cycles       = r_cycles;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench for legv8_multicycle_ctrl: directed program from the
// test plan, randomized instruction stream with random memory waits, reset
// mid-fetch and illegal-opcode halt, all against a per-instruction model.
module tb_legv8_multicycle_ctrl;

    localparam int K_ILL = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_R   = 3;
    localparam int K_CBZ = 4;
    localparam int K_B   = 5;

    logic        clk;
    logic        Reset_n = 1'b1;
    logic        alu_zero;
    logic [31:0] inst_out;
    logic [63:0] pc;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic [1:0]  ALUOp;
    logic [31:0] retired;
    logic        halted;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_pc;
    logic [31:0] m_ret;

    legv8_multicycle_ctrl_if #(.ADDR_W(64)) bus ();

    legv8_multicycle_ctrl #(
        .ADDR_W   (64),
        .PC_RESET (64'h0),
        .CNT_W    (32)
    ) dut (
        .Clock    (clk),
        .Reset_n  (Reset_n),
        .mem_bus  (bus),
        .alu_zero (alu_zero),
        .inst_out (inst_out),
        .pc       (pc),
        .Reg2Loc  (Reg2Loc),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUOp    (ALUOp),
        .retired  (retired),
        .halted   (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] i);
        logic [10:0] op;
        op = i[31:21];
        if (op == 11'h7C2) return K_LD;
        if (op == 11'h7C0) return K_ST;
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
        if (i[31:24] == 8'hB4) return K_CBZ;
        if (i[31:26] == 6'h05) return K_B;
        return K_ILL;
    endfunction

    // Byte offsets computed as signed integers
    function automatic longint off26(input logic [31:0] i);
        longint v;
        v = longint'(i[25:0]);
        if (v >= 33554432) v = v - 67108864;
        return v * 4;
    endfunction

    function automatic longint off19(input logic [31:0] i);
        longint v;
        v = longint'(i[23:5]);
        if (v >= 262144) v = v - 524288;
        return v * 4;
    endfunction

    function automatic logic [31:0] rand_instr(input int k);
        logic [31:0] r;
        logic [10:0] rops [4];
        rops = '{11'h458, 11'h658, 11'h450, 11'h550};
        r = $urandom();
        case (k)
            K_LD:  return {11'h7C2, r[20:0]};
            K_ST:  return {11'h7C0, r[20:0]};
            K_R:   return {rops[$urandom_range(0, 3)], r[20:0]};
            K_CBZ: return {8'hB4, r[23:0]};
            K_B:   return {6'h05, r[25:0]};
            default: begin
                while (classify(r) != K_ILL) r = $urandom();
                return r;
            end
        endcase
    endfunction

    // Assert reset, check reset state, release; returns in the first FETCH cycle
    task automatic do_reset();
        Reset_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #7;
        check("rst_pc", pc, 64'h0);
        check("rst_inst", inst_out, 0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_reqs", {bus.imem_req, bus.dmem_req, bus.dmem_we}, 0);
        check("rst_ctrl", {Reg2Loc, ALUSrc, MemtoReg, RegWrite, ALUOp}, 0);
        @(negedge clk);
        Reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_pc  = 64'h0;
        m_ret = 32'h0;
    endtask

    // Act as memory for one instruction and compare against the model.
    // Entered and left #1 after the edge that starts a FETCH (or shows HALT).
    task automatic run_instr(input logic [31:0] instr, input int fw, input int dw,
                             input logic z, input string tag);
        int kind, c, fcnt, dcnt, rw_idx;
        bit fdone, halt_seen, timeout;
        int n_dm, n_we, n_rw, n_mtr, n_src, n_op2, n_op1, n_r2l;
        int e_cyc, e_dm, e_we, e_rw, e_mtr, e_src, e_op2, e_op1, e_r2l, e_rwidx;
        logic [63:0] e_pc;
        logic [31:0] e_ret;

        kind = classify(instr);
        check({tag, "_fetch_req"}, bus.imem_req, 1);
        check({tag, "_fetch_addr"}, bus.imem_addr, m_pc);

        c = 0; fcnt = 0; dcnt = 0; rw_idx = -1;
        fdone = 0; halt_seen = 0; timeout = 0;
        n_dm = 0; n_we = 0; n_rw = 0; n_mtr = 0; n_src = 0; n_op2 = 0; n_op1 = 0; n_r2l = 0;
        bus.imem_rdata = instr;
        alu_zero = z;
        forever begin
            if (c > 0 && fdone && bus.imem_req) break;
            if (halted) begin halt_seen = 1; break; end
            if (c >= 64) begin timeout = 1; break; end
            if (bus.dmem_req) begin
                n_dm++;
                if (bus.dmem_we) n_we++;
            end
            if (RegWrite) begin
                n_rw++;
                if (rw_idx < 0) rw_idx = c;
            end
            if (MemtoReg) n_mtr++;
            if (ALUSrc) n_src++;
            if (ALUOp == 2'b10) n_op2++;
            if (ALUOp == 2'b01) n_op1++;
            if (Reg2Loc) n_r2l++;
            bus.imem_ready = bus.imem_req && (fcnt == fw);
            if (bus.imem_req) begin
                if (fcnt == fw) fdone = 1;
                fcnt++;
            end
            bus.dmem_ready = bus.dmem_req && (dcnt == dw);
            if (bus.dmem_req) dcnt++;
            @(posedge clk);
            #1;
            c++;
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        e_dm = 0; e_we = 0; e_rw = 0; e_mtr = 0; e_src = 0; e_op2 = 0; e_op1 = 0; e_r2l = 0;
        e_rwidx = 0;
        e_pc  = m_pc + 64'd4;
        e_ret = m_ret + 32'd1;
        case (kind)
            K_R: begin
                e_cyc = fw + 4; e_rw = 1; e_op2 = 1; e_rwidx = fw + 3;
            end
            K_LD: begin
                e_cyc = fw + dw + 5; e_dm = dw + 1; e_rw = 1; e_mtr = 1; e_src = 1;
                e_rwidx = fw + dw + 4;
            end
            K_ST: begin
                e_cyc = fw + dw + 4; e_dm = dw + 1; e_we = dw + 1; e_src = 1; e_r2l = dw + 2;
            end
            K_CBZ: begin
                e_cyc = fw + 3; e_op1 = 1; e_r2l = 1;
                if (z) e_pc = m_pc + 64'(off19(instr));
            end
            K_B: begin
                e_cyc = fw + 2;
                e_pc  = m_pc + 64'(off26(instr));
            end
            default: begin
                e_cyc = fw + 2;
                e_ret = m_ret;
            end
        endcase

        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_halt"}, halt_seen, kind == K_ILL);
        check({tag, "_cycles"}, c, e_cyc);
        check({tag, "_dmem_req_cycles"}, n_dm, e_dm);
        check({tag, "_dmem_we_cycles"}, n_we, e_we);
        check({tag, "_regwrite_cycles"}, n_rw, e_rw);
        check({tag, "_memtoreg_cycles"}, n_mtr, e_mtr);
        check({tag, "_alusrc_cycles"}, n_src, e_src);
        check({tag, "_aluop10_cycles"}, n_op2, e_op2);
        check({tag, "_aluop01_cycles"}, n_op1, e_op1);
        check({tag, "_reg2loc_cycles"}, n_r2l, e_r2l);
        if (e_rw == 1) check({tag, "_regwrite_cycle_idx"}, rw_idx, e_rwidx);
        if (kind != K_ILL) begin
            check({tag, "_pc"}, pc, e_pc);
            check({tag, "_next_fetch_addr"}, bus.imem_addr, e_pc);
        end
        check({tag, "_retired"}, retired, e_ret);
        m_pc  = e_pc;
        m_ret = e_ret;
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        alu_zero       = 1'b0;
        m_pc           = 64'h0;
        m_ret          = 32'h0;
        #1;
        do_reset();

        // Directed program
        run_instr(32'h8B020020, 0, 0, 1'b0, "add_pc0");
        check("add_pc0_pc4", pc, 64'h4);
        check("add_pc0_ret1", retired, 1);
        run_instr(32'hF8400020, 0, 2, 1'b0, "ldur_wait2");
        run_instr(32'h8B020020, 1, 0, 1'b0, "add_pc8");
        run_instr(32'hCB020020, 0, 0, 1'b0, "sub_pcc");
        check("reach_pc10", pc, 64'h10);
        run_instr(32'hB4000060, 0, 0, 1'b1, "cbz_taken");
        check("cbz_taken_pc", pc, 64'h1C);
        run_instr(32'h17FFFFFD, 0, 0, 1'b0, "b_back3");
        run_instr(32'hB4000060, 0, 0, 1'b0, "cbz_not_taken");
        check("cbz_not_taken_pc", pc, 64'h14);
        run_instr(32'h14000003, 2, 0, 1'b0, "b_fwd3");
        run_instr(32'h17FFFFFF, 0, 0, 1'b0, "b_minus1");
        check("b_minus1_pc", pc, 64'h1C);
        run_instr(32'hF8000020, 0, 1, 1'b0, "stur_wait1");

        // Randomized stream
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(1, 5);
            run_instr(rand_instr(k), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), "rand");
        end

        // Reset while a fetch is stalled
        bus.imem_ready = 1'b0;
        @(posedge clk);
        #3;
        check("midfetch_req_before", bus.imem_req, 1);
        Reset_n = 1'b0;
        #1;
        check("midfetch_req_drop", bus.imem_req, 0);
        check("midfetch_retired", retired, 0);
        check("midfetch_pc", pc, 64'h0);
        do_reset();
        run_instr(32'h8A020020, 0, 0, 1'b0, "and_after_rst");
        for (int n = 0; n < 8; n++) begin
            int k;
            k = $urandom_range(1, 5);
            run_instr(rand_instr(k), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), "rand2");
        end

        // Illegal opcode halts and stays halted without requests
        run_instr(32'h00000000, 0, 0, 1'b0, "illegal_zero");
        for (int n = 0; n < 5; n++) begin
            check("halt_no_imem_req", bus.imem_req, 0);
            check("halt_no_dmem_req", bus.dmem_req, 0);
            check("halt_held", halted, 1);
            @(posedge clk);
            #1;
        end
        do_reset();
        check("post_halt_pc", pc, 64'h0);
        check("post_halt_halted", halted, 0);
        run_instr(rand_instr(K_ILL), 1, 0, 1'b0, "illegal_rand");
        check("illegal_rand_halted", halted, 1);
        do_reset();
        run_instr(32'h8B020020, 0, 0, 1'b0, "add_final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
